ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Parametrised instruction-fetch unit: holds the program counter, issues reads to an external synchronous program memory, and buffers returned instructions with their addresses in a small queue. Decode consumes from the queue over a valid/ready handshake. It sits between program memory and the decode stage and replaces hold-register stalling with queue back-pressure and replay with branch flush. Widths, queue depth and reset vector are parameters.

## Interface
- ADDR_W, 8, program-counter and memory address width
- INS_W, 24, instruction width
- QDEPTH, 4, queue entries; power of two, ≥4
- RESET_PC, 0, fetch address after reset
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; low clears all state
- pm_addr  out  ADDR_W  program memory read address
- pm_rd_en  out  1  read strobe; data returns on pm_data next cycle
- pm_data  in  INS_W  read data, valid the cycle after pm_rd_en
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1
- ins  out  INS_W  head-of-queue instruction
- ins_pc  out  ADDR_W  address of ins
- ins_valid  out  1  head entry valid
- ins_ready  in  1  decode accepts; low = stall
- q_level  out  clog2(QDEPTH)+1  occupied entries (debug)

## Operation
- Registers: fetch_pc (ADDR_W), pend (1 bit, read in flight), pend_pc (ADDR_W), queue of {pc, ins}, count.
- Issue: pm_rd_en = reset & ~redirect & (count + pend < QDEPTH); pm_addr = fetch_pc. On issue: fetch_pc <= fetch_pc+1 (mod 2^ADDR_W, 0xFF→0x00 at ADDR_W=8), pend <= 1, pend_pc <= fetch_pc; otherwise pend <= 0.
- Return: if pend=1 and no redirect this cycle, push {pend_pc, pm_data} at the clock edge.
- Pop: when ins_valid & ins_ready & ~redirect.
- Push and pop in the same cycle: count unchanged. Empty queue has no bypass; a pushed entry is visible the next cycle.
- The credit rule makes push-when-full impossible. The bench asserts it never happens.
- Redirect (priority over everything): count <= 0, pend <= 0 (in-flight data discarded), fetch_pc <= redirect_pc, no issue, no pop. A head entry presented during the redirect cycle is not consumed.
- Stall: while ins_ready=0, ins, ins_pc and ins_valid stay stable. Fetch continues until count+pend = QDEPTH, then pm_rd_en stays low.
- ins, ins_pc: 0 when ins_valid=0.

## Timing
- Reset values: pm_addr=RESET_PC, pm_rd_en=0 while reset low, ins=0, ins_pc=0, ins_valid=0, q_level=0, pend=0.
- Cycle 0 = first cycle with reset high: pm_rd_en=1, pm_addr=RESET_PC. Cycle 1: data returns and is pushed. Cycle 2: ins_valid=1, ins_pc=RESET_PC.
- Redirect at cycle t: t+1 ins_valid=0 and pm_addr=redirect_pc issued. t+2 data returns. t+3 ins_valid=1.
- Steady state with ins_ready=1: one instruction per cycle, no bubbles.
- Reset asserted mid-operation: all state cleared asynchronously, in-flight read discarded, restart per above.

## Structure
- Shared package/header: default ADDR_W, INS_W, QDEPTH, RESET_PC constants; queue entry type {pc, ins}.
- Sub-module ins_queue: synchronous FIFO (WIDTH = ADDR_W+INS_W, DEPTH = QDEPTH), push/pop/flush, count, head output. Wrapping read/write pointers with extra MSB.
- Top level holds the PC, in-flight tracking, credit logic and redirect control. Program memory stays external.

## Test plan
- Reset release, ins_ready=1, mem[a]=24'hF00000+a → ins_valid at cycle 2; ins = F00000, F00001, F00002… on consecutive cycles with matching ins_pc 0,1,2.
- Hold ins_ready=0 from cycle 2 → q_level rises to 4, pm_rd_en=0 thereafter, and ins=F00000 stays stable. Release → F00000..F00003 then F00004 with no gap or duplicate.
- Redirect to 8'h40 at cycle 6 with ins_ready=1 → ins_valid=0 at cycles 7–8, ins=F00040 with ins_pc=40 at cycle 9, and no pre-redirect instruction is delivered afterwards.
- RESET_PC=8'hFE, free-run → ins_pc sequence FE, FF, 00, 01.
- Redirect while queue is full and stalled, plus back-to-back redirects at t and t+1 (to 10, then 20) → only 20, 21… are delivered.
- Assert reset mid-stream for 1 cycle → outputs 0 immediately (asynchronous), restart from RESET_PC at cycle 2 after release.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_queue_pkg                                                     |
// | Default widths, depth and reset vector shared by the fetch unit.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package ifetch_queue_pkg;

  localparam int unsigned C_ADDR_W   = 8;
  localparam int unsigned C_INS_W    = 24;
  localparam int unsigned C_QDEPTH   = 4;
  localparam logic [C_ADDR_W-1:0] C_RESET_PC = '0;

  // Queue entry at default widths; the queue itself stores {pc, ins} flat.
  typedef struct packed {
    logic [C_ADDR_W-1:0] pc;
    logic [C_INS_W-1:0]  ins;
  } q_entry_t;

endpackage

`default_nettype wire

// File: rtl/ins_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ins_queue                                                            |
// | Synchronous FIFO with flush; head is shown without a read strobe.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ins_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = C_ADDR_W + C_INS_W,
  parameter int unsigned DEPTH = C_QDEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB distinguishes full from empty when the low bits match.
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wptr[PTR_W-1:0]] <= wdata;
  end

  assign head  = r_mem[r_rptr[PTR_W-1:0]];
  assign count = r_wptr - r_rptr;

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_queue                                                         |
// | PC, program-memory read issue with credit, instruction queue.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned        ADDR_W   = C_ADDR_W,
  parameter int unsigned        INS_W    = C_INS_W,
  parameter int unsigned        QDEPTH   = C_QDEPTH,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(C_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        pm_addr,
  output logic                     pm_rd_en,
  input  logic [INS_W-1:0]         pm_data,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [INS_W-1:0]         ins,
  output logic [ADDR_W-1:0]        ins_pc,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  output logic [$clog2(QDEPTH):0]  q_level
);

  localparam int unsigned LVL_W = $clog2(QDEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INS_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_pc;

  logic [LVL_W-1:0]  w_count;
  logic [LVL_W:0]    w_inflight;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;

  // Credit counts the read in flight so the queue can never overflow.
  assign w_inflight = {1'b0, w_count} + {{LVL_W{1'b0}}, r_pend};
  assign w_issue    = reset & ~redirect & (w_inflight < (LVL_W+1)'(QDEPTH));
  assign w_push     = r_pend & ~redirect;
  assign w_pop      = ins_valid & ins_ready & ~redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_pc  <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_pend     <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
        r_pend_pc  <= r_fetch_pc;
      end
    end
  end

  ins_queue #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .wdata ({r_pend_pc, pm_data}),
    .head  (w_head),
    .count (w_count)
  );

  assign pm_addr   = r_fetch_pc;
  assign pm_rd_en  = w_issue;
  assign q_level   = w_count;
  assign ins_valid = (w_count != '0);
  assign ins       = ins_valid ? w_head[INS_W-1:0] : '0;
  assign ins_pc    = ins_valid ? w_head[ENT_W-1 -: ADDR_W] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifetch_queue                                                      |
// | Directed-vector bench for ifetch_queue (RESET_PC 00 and FE).        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        ins_ready = 1'b1;
  logic [7:0]  pm_addr;
  logic        pm_rd_en;
  logic [23:0] pm_data = '0;
  logic [23:0] ins;
  logic [7:0]  ins_pc;
  logic        ins_valid;
  logic [2:0]  q_level;

  logic        fe_redirect = 1'b0;
  logic [7:0]  fe_redirect_pc = 8'h00;
  logic        fe_ready = 1'b1;
  logic [7:0]  fe_pm_addr;
  logic        fe_pm_rd_en;
  logic [23:0] fe_pm_data = '0;
  logic [23:0] fe_ins;
  logic [7:0]  fe_ins_pc;
  logic        fe_ins_valid;
  logic [2:0]  fe_q_level;

  int checks = 0;
  int errors = 0;
  int full_push_viol = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.ADDR_W(8), .INS_W(24), .QDEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .pm_addr(pm_addr), .pm_rd_en(pm_rd_en), .pm_data(pm_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .ins(ins), .ins_pc(ins_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .q_level(q_level)
  );

  ifetch_queue #(.ADDR_W(8), .INS_W(24), .QDEPTH(4), .RESET_PC(8'hFE)) dut_fe (
    .clk(clk), .reset(reset), .pm_addr(fe_pm_addr), .pm_rd_en(fe_pm_rd_en), .pm_data(fe_pm_data),
    .redirect(fe_redirect), .redirect_pc(fe_redirect_pc), .ins(fe_ins), .ins_pc(fe_ins_pc),
    .ins_valid(fe_ins_valid), .ins_ready(fe_ready), .q_level(fe_q_level)
  );

  // Program memories: mem[a] = F00000 + a, one-cycle read latency.
  always @(posedge clk) if (pm_rd_en)    pm_data    <= 24'hF00000 + {16'h0, pm_addr};
  always @(posedge clk) if (fe_pm_rd_en) fe_pm_data <= 24'hF00000 + {16'h0, fe_pm_addr};

  // A return arriving while the queue is already full would be lost.
  always @(negedge clk)
    if (reset && !redirect && dut.r_pend && q_level == 3'd4) full_push_viol++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0; redirect = 1'b0; ins_ready = 1'b1;
    step();
    step();
  endtask

  // Leaves the bench just after the edge that starts cycle 0.
  task automatic start();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    #1;
    checks++; if (pm_rd_en !== 1'b0)   begin errors++; $display("FAIL reset_rd_en got %0b want 0", pm_rd_en); end
    checks++; if (pm_addr !== 8'h00)   begin errors++; $display("FAIL reset_addr got %h want 00", pm_addr); end
    checks++; if (ins_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b want 0", ins_valid); end
    checks++; if (ins !== 24'h0 || ins_pc !== 8'h0) begin errors++; $display("FAIL reset_ins got %h/%h want 0/0", ins, ins_pc); end
    checks++; if (q_level !== 3'd0)    begin errors++; $display("FAIL reset_level got %0d want 0", q_level); end
    checks++; if (fe_pm_addr !== 8'hFE) begin errors++; $display("FAIL reset_fe_addr got %h want fe", fe_pm_addr); end
  endtask

  task automatic test_free_run();
    logic [7:0] fe_pc;
    hold_reset();
    start();
    #1;
    checks++; if (pm_rd_en !== 1'b1 || pm_addr !== 8'h00) begin errors++; $display("FAIL run_c0_issue got %0b/%h want 1/00", pm_rd_en, pm_addr); end
    step(); #1;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL run_c1_valid got %0b want 0", ins_valid); end
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      fe_pc = 8'hFE + 8'(k);
      checks++; if (ins_valid !== 1'b1 || ins !== 24'hF00000 + 24'(k) || ins_pc !== 8'(k))
        begin errors++; $display("FAIL run_seq%0d got %0b/%h/%h want 1/%h/%h", k, ins_valid, ins, ins_pc, 24'hF00000 + 24'(k), 8'(k)); end
      checks++; if (fe_ins_valid !== 1'b1 || fe_ins_pc !== fe_pc || fe_ins !== 24'hF00000 + {16'h0, fe_pc})
        begin errors++; $display("FAIL wrap_seq%0d got %0b/%h/%h want 1/%h", k, fe_ins_valid, fe_ins, fe_ins_pc, fe_pc); end
    end
  endtask

  task automatic test_stall();
    hold_reset();
    start();
    ins_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step(); #1;
      if (c >= 2) begin
        checks++; if (ins_valid !== 1'b1 || ins !== 24'hF00000 || ins_pc !== 8'h00)
          begin errors++; $display("FAIL stall_hold_c%0d got %0b/%h/%h want 1/f00000/00", c, ins_valid, ins, ins_pc); end
      end
    end
    checks++; if (q_level !== 3'd4) begin errors++; $display("FAIL stall_level got %0d want 4", q_level); end
    checks++; if (pm_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en got %0b want 0", pm_rd_en); end
    for (int k = 0; k < 5; k++) begin
      step();
      ins_ready = 1'b1;
      #1;
      checks++; if (ins_valid !== 1'b1 || ins !== 24'hF00000 + 24'(k) || ins_pc !== 8'(k))
        begin errors++; $display("FAIL stall_release%0d got %0b/%h/%h want 1/%h", k, ins_valid, ins, ins_pc, 24'hF00000 + 24'(k)); end
    end
  endtask

  task automatic test_redirect();
    hold_reset();
    start();
    ins_ready = 1'b1;
    repeat (6) step();
    redirect = 1'b1; redirect_pc = 8'h40;
    #1;
    checks++; if (ins !== 24'hF00004 || pm_rd_en !== 1'b0)
      begin errors++; $display("FAIL redir_c6 got %h/%0b want f00004/0", ins, pm_rd_en); end
    step();
    redirect = 1'b0;
    #1;
    checks++; if (ins_valid !== 1'b0 || pm_addr !== 8'h40 || pm_rd_en !== 1'b1)
      begin errors++; $display("FAIL redir_c7 got %0b/%h/%0b want 0/40/1", ins_valid, pm_addr, pm_rd_en); end
    step(); #1;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL redir_c8 got %0b want 0", ins_valid); end
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      checks++; if (ins_valid !== 1'b1 || ins !== 24'hF00040 + 24'(k) || ins_pc !== 8'h40 + 8'(k))
        begin errors++; $display("FAIL redir_seq%0d got %0b/%h/%h want 1/%h", k, ins_valid, ins, ins_pc, 24'hF00040 + 24'(k)); end
    end
  endtask

  task automatic test_back_to_back();
    hold_reset();
    start();
    ins_ready = 1'b0;
    repeat (8) step();
    redirect = 1'b1; redirect_pc = 8'h10;
    #1;
    checks++; if (pm_rd_en !== 1'b0 || q_level !== 3'd4)
      begin errors++; $display("FAIL b2b_c8 got %0b/%0d want 0/4", pm_rd_en, q_level); end
    step();
    redirect_pc = 8'h20;
    #1;
    checks++; if (ins_valid !== 1'b0 || pm_rd_en !== 1'b0)
      begin errors++; $display("FAIL b2b_c9 got %0b/%0b want 0/0", ins_valid, pm_rd_en); end
    step();
    redirect = 1'b0; ins_ready = 1'b1;
    #1;
    checks++; if (ins_valid !== 1'b0 || pm_addr !== 8'h20)
      begin errors++; $display("FAIL b2b_c10 got %0b/%h want 0/20", ins_valid, pm_addr); end
    step(); #1;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL b2b_c11 got %0b want 0", ins_valid); end
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      checks++; if (ins_valid !== 1'b1 || ins !== 24'hF00020 + 24'(k) || ins_pc !== 8'h20 + 8'(k))
        begin errors++; $display("FAIL b2b_seq%0d got %0b/%h/%h want 1/%h", k, ins_valid, ins, ins_pc, 24'hF00020 + 24'(k)); end
    end
  endtask

  task automatic test_async_reset();
    hold_reset();
    start();
    ins_ready = 1'b1;
    repeat (4) step();
    #1;
    checks++; if (ins_valid !== 1'b1 || ins !== 24'hF00002)
      begin errors++; $display("FAIL areset_pre got %0b/%h want 1/f00002", ins_valid, ins); end
    reset = 1'b0;
    #1;
    checks++; if (ins_valid !== 1'b0 || ins !== 24'h0 || ins_pc !== 8'h0 || q_level !== 3'd0)
      begin errors++; $display("FAIL areset_clear got %0b/%h/%h/%0d want 0/0/0/0", ins_valid, ins, ins_pc, q_level); end
    checks++; if (pm_rd_en !== 1'b0 || pm_addr !== 8'h00)
      begin errors++; $display("FAIL areset_pm got %0b/%h want 0/00", pm_rd_en, pm_addr); end
    step();
    reset = 1'b1;
    #1;
    checks++; if (pm_rd_en !== 1'b1 || pm_addr !== 8'h00)
      begin errors++; $display("FAIL areset_c0 got %0b/%h want 1/00", pm_rd_en, pm_addr); end
    step(); #1;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL areset_c1 got %0b want 0", ins_valid); end
    step(); #1;
    checks++; if (ins_valid !== 1'b1 || ins !== 24'hF00000 || ins_pc !== 8'h00)
      begin errors++; $display("FAIL areset_c2 got %0b/%h/%h want 1/f00000/00", ins_valid, ins, ins_pc); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    checks++; if (full_push_viol !== 0)
      begin errors++; $display("FAIL push_when_full got %0d want 0", full_push_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
